uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Sequencing controller for the UART receive path.
- Detects and qualifies the start bit, then launches the data-bit and stop-bit sampler sub-blocks in order using start-pulse/ready handshakes.
- Checks stop-bit framing (and optionally parity), and presents each received byte on a valid/ack output interface.
- Sits between the raw synchronised RX line plus oversample tick and the sampler instances; downstream it feeds the byte consumer (FIFO or core).

Parameters:
- OSR, 16, oversample ticks per bit; even, at least 4.
- DATA_BITS, 8, data bits per frame; 5..9.
- STOP_BITS, 2, stop bits per frame; 1..2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-high reset
- i_en  in  1  oversample tick, one cycle wide, OSR per bit period
- i_rx  in  1  serial RX line (asynchronous; double-flopped internally)
- o_data_start  out  1  one-cycle start pulse to data-bit sampler
- i_data_ready  in  1  data-bit sampler done (level, sampled while waiting)
- i_data  in  DATA_BITS  sampler result, LSB first received
- o_stop_start  out  1  one-cycle start pulse to stop-bit sampler
- i_stop_ready  in  1  stop-bit sampler done
- o_data  out  DATA_BITS  received byte
- o_valid  out  1  byte available
- i_ack  in  1  consumer accepts byte
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: frame completed while o_valid still high
- o_busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - All outputs 0; o_data = 0.
  - Sync flops = 1; tick counter = 0.
- Synchroniser and state machine timing:
  - i_rx passes through a 2-FF synchroniser to give rx_s.
  - All state transitions occur only on cycles where i_en = 1, except the handshake waits.
  - The handshake waits react to ready in any cycle.
- IDLE:
  - On an i_en tick with rx_s = 0, go to START with counter = 1.
- START (start-bit qualification):
  - Count i_en ticks.
  - When counter reaches OSR/2: if rx_s = 0, pulse o_data_start and go to DATA.
  - Otherwise it was a glitch: return to IDLE, no output.
- DATA:
  - o_data_start is high for exactly one cycle on entry.
  - Wait for i_data_ready = 1, then capture i_data into a shadow register.
  - Clear the counter; go to STOP (or PARITY when enabled).
- STOP:
  - Pulse o_stop_start for one cycle on entry.
  - Count i_en ticks modulo OSR and sample rx_s when the count equals OSR/2. Any sample of 0 sets an internal frame-error flag.
  - Wait for i_stop_ready, then go to DONE.
- DONE (exactly one cycle):
  - If the frame-error flag is set: pulse o_frame_err; the byte is discarded and o_valid is unchanged.
  - Else if o_valid = 1 and i_ack = 0: pulse o_overrun; the held byte is kept and the new byte is dropped.
  - Else: load o_data from the shadow register and set o_valid = 1.
  - Then return to IDLE.
- Output handshake:
  - o_valid stays high until a cycle with i_ack = 1, then clears the next cycle.
  - An ack in the same cycle as a DONE load: the load wins and o_valid stays 1 with the new byte.
  - i_ack while o_valid = 0 is ignored.
- Reset mid-frame: returns to IDLE immediately with no pulses; a partially received byte is lost.
- Back-to-back frames:
  - IDLE may detect the next start on the first tick after DONE.
  - A line held low after the stop bit is treated as a new start.
- Ready received before the corresponding start pulse has no effect; ready is only observed in its wait state.

Optional Feature:
- Macro: UART_RX_CTRL_PARITY_EN.
- When defined:
  - Adds input i_parity_odd (1 = odd parity, 0 = even) and a PARITY state between DATA and STOP.
  - PARITY counts OSR i_en ticks and samples rx_s at OSR/2.
  - Expected parity bit = XOR of the captured data, inverted when i_parity_odd = 1.
  - Adds output o_parity_err: a one-cycle pulse in DONE on mismatch. The byte is discarded as for a framing error; framing error takes reporting priority and both pulse together if both occur.
- When undefined: no PARITY state and no extra ports; DATA goes directly to STOP.

Test Plan:
- Clean frame: 0x5A with 2 stop bits, sampler models returning ready -> o_valid = 1 with o_data = 0x5A one cycle after DONE; o_frame_err = 0; then i_ack -> o_valid = 0 the next cycle.
- False start: rx low for OSR/4 ticks then high -> no o_data_start, returns to IDLE, o_busy drops, no outputs.
- Framing error: 0xA5 with first stop bit low -> single-cycle o_frame_err, o_valid stays 0, the next clean frame 0x3C is received normally.
- Overrun: receive 0x11 and withhold ack, then receive 0x22 -> o_overrun pulses once, o_data stays 0x11; ack -> o_valid drops.
- Reset mid-DATA: assert i_rst while waiting for i_data_ready -> all outputs 0 and state IDLE the next cycle; a later frame 0x7E is received correctly.
- With UART_RX_CTRL_PARITY_EN, i_parity_odd = 0, byte 0x07 -> parity bit 1 gives o_valid = 1; parity bit 0 gives an o_parity_err pulse and the byte is dropped.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing controller: qualifies the start bit, hands off to the data and stop samplers,
// checks framing and presents each byte on a valid/ack interface. Define UART_RX_CTRL_PARITY_EN for the parity stage.
module uart_rx_ctrl #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_rx,
    output logic                 o_data_start,
    input  logic                 i_data_ready,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_stop_start,
    input  logic                 i_stop_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ack,
    output logic                 o_frame_err,
    output logic                 o_overrun,
`ifdef UART_RX_CTRL_PARITY_EN
    input  logic                 i_parity_odd,
    output logic                 o_parity_err,
`endif
    output logic                 o_busy
);

    localparam int CW = $clog2(OSR) + 1;
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(OSR / 2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(OSR);
    localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
`ifdef UART_RX_CTRL_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd5;
`endif

    logic                 sync_meta_r;
    logic                 rx_sync_r;
    logic [2:0]           state_r;
    logic [2:0]           state_nxt_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        cnt_nxt_s;
    logic [CW-1:0]        cnt_inc_s;
    logic                 sample_s;
    logic [DATA_BITS-1:0] shadow_r;
    logic                 ferr_r;
    logic [1:0]           stop_idx_r;
    logic                 perr_s;
    logic                 drop_s;
    logic                 hold_s;

`ifdef UART_RX_CTRL_PARITY_EN
    logic perr_r;

    function automatic logic parity_expected(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

    // Two-flop synchroniser for the asynchronous RX line (idles high).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_meta_r <= 1'b1;
            rx_sync_r   <= 1'b1;
        end else begin
            sync_meta_r <= i_rx;
            rx_sync_r   <= sync_meta_r;
        end
    end

    // Next-state and tick-counter logic; only handshake waits react outside oversample ticks.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cnt_inc_s   = cnt_r + CNT_ONE;
        sample_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_en && !rx_sync_r) begin
                    state_nxt_s = ST_START;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_en && (cnt_inc_s == CNT_HALF)) begin
                    state_nxt_s = rx_sync_r ? ST_IDLE : ST_DATA;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (i_en) begin
                    cnt_nxt_s = cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_DATA: begin
                if (i_data_ready) begin
`ifdef UART_RX_CTRL_PARITY_EN
                    state_nxt_s = ST_PARITY;
`else
                    state_nxt_s = ST_STOP;
`endif
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_RX_CTRL_PARITY_EN
            ST_PARITY: begin
                if (i_en) begin
                    sample_s = (cnt_inc_s == CNT_HALF);
                    if (cnt_inc_s == CNT_FULL) begin
                        state_nxt_s = ST_STOP;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
`endif
            ST_STOP: begin
                if (i_en) begin
                    sample_s  = (cnt_inc_s == CNT_HALF);
                    cnt_nxt_s = (cnt_inc_s == CNT_FULL) ? CNT_ZERO : cnt_inc_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (i_stop_ready) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // A completed frame is dropped on any error; a held byte that is not being acked blocks the load.
    assign drop_s = ferr_r | perr_s;
    assign hold_s = o_valid & ~i_ack;

    // State register, sampler pulses, stop-bit framing check and the valid/ack output stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            shadow_r     <= {DATA_BITS{1'b0}};
            ferr_r       <= 1'b0;
            stop_idx_r   <= 2'd0;
            o_busy       <= 1'b0;
            o_data_start <= 1'b0;
            o_stop_start <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_data       <= {DATA_BITS{1'b0}};
            o_valid      <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            o_busy       <= (state_nxt_s != ST_IDLE);
            o_data_start <= (state_r == ST_START) && (state_nxt_s == ST_DATA);
            o_stop_start <= (state_r != ST_STOP) && (state_nxt_s == ST_STOP);
            o_frame_err  <= (state_r == ST_DONE) && ferr_r;
            o_overrun    <= (state_r == ST_DONE) && !drop_s && hold_s;
            if ((state_r == ST_DATA) && i_data_ready) begin
                shadow_r   <= i_data;
                ferr_r     <= 1'b0;
                stop_idx_r <= 2'd0;
            end else if ((state_r == ST_STOP) && sample_s && (stop_idx_r < STOP_LAST)) begin
                stop_idx_r <= stop_idx_r + 2'd1;
                ferr_r     <= ferr_r | ~rx_sync_r;
            end
            if ((state_r == ST_DONE) && !drop_s && !hold_s) begin
                o_data  <= shadow_r;
                o_valid <= 1'b1;
            end else if (o_valid && i_ack) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_CTRL_PARITY_EN
    // Parity bit check; the flag is cleared when a new byte is captured.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perr_r       <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            o_parity_err <= (state_r == ST_DONE) && perr_r;
            if ((state_r == ST_DATA) && i_data_ready) begin
                perr_r <= 1'b0;
            end else if ((state_r == ST_PARITY) && sample_s) begin
                perr_r <= (rx_sync_r != parity_expected(shadow_r, i_parity_odd));
            end
        end
    end

    assign perr_s = perr_r;
`else
    assign perr_s = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: serial frames are generated tick by tick, sampler handshakes are
// modelled, and outcomes are predicted from the frame contents by a byte-level reference model.
module tb_uart_rx_ctrl;
    localparam int OSR = 16;
    localparam int DB  = 8;
    localparam int SB  = 2;
`ifdef UART_RX_CTRL_PARITY_EN
    localparam int PB  = 1;
`else
    localparam int PB  = 0;
`endif
    localparam int DATA_END    = OSR * (1 + DB);
    localparam int FRAME_TICKS = OSR * (1 + DB + PB + SB);

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          en         = 1'b0;
    logic          rx         = 1'b1;
    logic          data_ready = 1'b0;
    logic          stop_ready = 1'b0;
    logic          ack        = 1'b0;
    logic [DB-1:0] data_in    = 8'h00;
    logic          data_start, stop_start, valid, frame_err, overrun, busy;
    logic [DB-1:0] data_out;
`ifdef UART_RX_CTRL_PARITY_EN
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    int vectors = 0, miscompares = 0;
    int n_dstart = 0, n_sstart = 0, n_ferr = 0, n_ovr = 0, n_perr = 0;
    int e_dstart = 0, e_sstart = 0, e_ferr = 0, e_ovr = 0, e_perr = 0;
    logic          e_valid = 1'b0;
    logic [DB-1:0] e_data  = 8'h00;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.OSR(OSR), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_rx(rx),
        .o_data_start(data_start), .i_data_ready(data_ready), .i_data(data_in),
        .o_stop_start(stop_start), .i_stop_ready(stop_ready),
        .o_data(data_out), .o_valid(valid), .i_ack(ack),
        .o_frame_err(frame_err), .o_overrun(overrun),
`ifdef UART_RX_CTRL_PARITY_EN
        .i_parity_odd(parity_odd), .o_parity_err(parity_err),
`endif
        .o_busy(busy)
    );

    // Count high cycles of every pulse output, sampled mid-cycle.
    always @(negedge clk) begin
        if (data_start === 1'b1) n_dstart <= n_dstart + 1;
        if (stop_start === 1'b1) n_sstart <= n_sstart + 1;
        if (frame_err === 1'b1)  n_ferr   <= n_ferr + 1;
        if (overrun === 1'b1)    n_ovr    <= n_ovr + 1;
`ifdef UART_RX_CTRL_PARITY_EN
        if (parity_err === 1'b1) n_perr   <= n_perr + 1;
`endif
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // One oversample tick every four clocks.
    task automatic tick();
        clk1(); en = 1'b1;
        clk1(); en = 1'b0;
        clk1(); clk1();
    endtask

    function automatic logic line_bit(input int k, input logic [DB-1:0] d, input logic [SB-1:0] stops,
                                      input logic pbit);
        logic [DB-1:0] ds;
        logic [SB-1:0] ss;
        if (k < OSR) return 1'b0;
        if (k < DATA_END) begin
            ds = d >> ((k - OSR) / OSR);
            return ds[0];
        end
        if (k < DATA_END + PB * OSR) return pbit;
        ss = stops >> ((k - DATA_END - PB * OSR) / OSR);
        return ss[0];
    endfunction

    // Reference model: outcome of one completed frame at byte level.
    function automatic void model_frame(input logic [DB-1:0] d, input logic [SB-1:0] stops, input logic par_bad);
        logic fe, pe;
        fe = (stops != {SB{1'b1}});
        pe = (PB == 1) && par_bad;
        e_dstart++;
        e_sstart++;
        if (fe) e_ferr++;
        if (pe) e_perr++;
        if (!fe && !pe) begin
            if (e_valid) e_ovr++;
            else begin
                e_valid = 1'b1;
                e_data  = d;
            end
        end
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic [SB-1:0] stops, input logic par_bad);
        logic pbit;
`ifdef UART_RX_CTRL_PARITY_EN
        pbit = (^d) ^ parity_odd ^ par_bad;
`else
        pbit = par_bad;
`endif
        for (int k = 0; k < FRAME_TICKS; k++) begin
            rx = line_bit(k, d, stops, pbit);
            if (k == DATA_END) begin
                data_in = d; data_ready = 1'b1; clk1(); data_ready = 1'b0;
            end
            tick();
        end
        rx = 1'b1;
        stop_ready = 1'b1; clk1(); stop_ready = 1'b0;
        clk1(); clk1();
        model_frame(d, stops, par_bad);
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1; clk1(); ack = 1'b0;
        e_valid = 1'b0;
        vectors++; if (valid !== e_valid) begin miscompares++; $display("FAIL %s_ack_clear: got %b want %b", tag, valid, e_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) clk1();
        vectors++; if ({data_start, stop_start, valid, frame_err, overrun, busy} !== 6'b000000) begin miscompares++; $display("FAIL reset_outs: got %b want 000000", {data_start, stop_start, valid, frame_err, overrun, busy}); end
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_out); end
        rst = 1'b0; repeat (2) tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_clean();
        send_frame(8'h5A, 2'b11, 1'b0);
        vectors++; if (valid !== e_valid) begin miscompares++; $display("FAIL clean_valid: got %b want %b", valid, e_valid); end
        vectors++; if (data_out !== e_data) begin miscompares++; $display("FAIL clean_data: got %h want %h", data_out, e_data); end
        vectors++; if (n_ferr !== e_ferr) begin miscompares++; $display("FAIL clean_ferr: got %0d want %0d", n_ferr, e_ferr); end
        vectors++; if (n_dstart !== e_dstart || n_sstart !== e_sstart) begin miscompares++; $display("FAIL clean_starts: got %0d/%0d want %0d/%0d", n_dstart, n_sstart, e_dstart, e_sstart); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL clean_busy: got %b want 0", busy); end
        repeat (3) clk1();
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL clean_hold: got %b want 1", valid); end
        do_ack("clean");
    endtask

    task automatic test_false_start();
        rx = 1'b0; repeat (OSR / 4) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL false_busy_start: got %b want 1", busy); end
        rx = 1'b1; repeat (OSR) tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL false_busy_end: got %b want 0", busy); end
        vectors++; if (n_dstart !== e_dstart) begin miscompares++; $display("FAIL false_dstart: got %0d want %0d", n_dstart, e_dstart); end
        data_ready = 1'b1; stop_ready = 1'b1; clk1(); data_ready = 1'b0; stop_ready = 1'b0;
        repeat (2) clk1();
        vectors++; if (busy !== 1'b0 || n_sstart !== e_sstart || valid !== e_valid) begin miscompares++; $display("FAIL stray_ready: got busy=%b sstart=%0d valid=%b want 0/%0d/%b", busy, n_sstart, valid, e_sstart, e_valid); end
    endtask

    task automatic test_frame_err();
        send_frame(8'hA5, 2'b10, 1'b0);
        vectors++; if (n_ferr !== e_ferr) begin miscompares++; $display("FAIL ferr_pulse: got %0d want %0d", n_ferr, e_ferr); end
        vectors++; if (valid !== e_valid) begin miscompares++; $display("FAIL ferr_valid: got %b want %b", valid, e_valid); end
        send_frame(8'h3C, 2'b11, 1'b0);
        vectors++; if (valid !== e_valid || data_out !== e_data) begin miscompares++; $display("FAIL ferr_next: got %b/%h want %b/%h", valid, data_out, e_valid, e_data); end
        do_ack("ferr");
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 2'b11, 1'b0);
        send_frame(8'h22, 2'b11, 1'b0);
        vectors++; if (n_ovr !== e_ovr) begin miscompares++; $display("FAIL ovr_pulse: got %0d want %0d", n_ovr, e_ovr); end
        vectors++; if (valid !== e_valid || data_out !== e_data) begin miscompares++; $display("FAIL ovr_hold: got %b/%h want %b/%h", valid, data_out, e_valid, e_data); end
        do_ack("ovr");
    endtask

    task automatic test_reset_mid();
        send_frame(DB'($urandom), 2'b11, 1'b0);
        rx = 1'b0;
        for (int j = 0; j < OSR && n_dstart == e_dstart; j++) tick();
        vectors++; if (n_dstart !== e_dstart + 1) begin miscompares++; $display("FAIL rstmid_dstart: got %0d want %0d", n_dstart, e_dstart + 1); end
        e_dstart++;
        repeat (3) tick();
        rst = 1'b1; clk1();
        vectors++; if ({data_start, stop_start, valid, frame_err, overrun, busy} !== 6'b000000 || data_out !== 8'h00) begin miscompares++; $display("FAIL rstmid_outs: got %b/%h want 000000/00", {data_start, stop_start, valid, frame_err, overrun, busy}, data_out); end
        rst = 1'b0; rx = 1'b1;
        e_valid = 1'b0; e_data = 8'h00;
        repeat (OSR) tick();
        send_frame(8'h7E, 2'b11, 1'b0);
        vectors++; if (valid !== e_valid || data_out !== e_data) begin miscompares++; $display("FAIL rstmid_next: got %b/%h want %b/%h", valid, data_out, e_valid, e_data); end
        do_ack("rstmid");
    endtask

`ifdef UART_RX_CTRL_PARITY_EN
    task automatic test_parity();
        parity_odd = 1'b0;
        send_frame(8'h07, 2'b11, 1'b0);
        vectors++; if (valid !== 1'b1 || data_out !== 8'h07) begin miscompares++; $display("FAIL parity_good: got %b/%h want 1/07", valid, data_out); end
        do_ack("parity");
        send_frame(8'h07, 2'b11, 1'b1);
        vectors++; if (n_perr !== e_perr || valid !== 1'b0) begin miscompares++; $display("FAIL parity_bad: got %0d/%b want %0d/0", n_perr, valid, e_perr); end
    endtask
`endif

    task automatic test_back_to_back();
        logic [DB-1:0] d;
        logic [SB-1:0] stops;
        logic          pbad;
        for (int i = 0; i < 12; i++) begin
            d     = DB'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? SB'($urandom_range(0, 2)) : 2'b11;
            pbad  = (PB == 1) && ($urandom_range(0, 3) == 0);
`ifdef UART_RX_CTRL_PARITY_EN
            parity_odd = 1'($urandom_range(0, 1));
`endif
            send_frame(d, stops, pbad);
            vectors++; if (valid !== e_valid || data_out !== e_data) begin miscompares++; $display("FAIL b2b_byte[%0d]: got %b/%h want %b/%h", i, valid, data_out, e_valid, e_data); end
            vectors++; if (n_ferr !== e_ferr || n_ovr !== e_ovr) begin miscompares++; $display("FAIL b2b_pulses[%0d]: got ferr=%0d ovr=%0d want %0d/%0d", i, n_ferr, n_ovr, e_ferr, e_ovr); end
            vectors++; if (n_dstart !== e_dstart || n_sstart !== e_sstart || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_seq[%0d]: got %0d/%0d/%b want %0d/%0d/0", i, n_dstart, n_sstart, busy, e_dstart, e_sstart); end
`ifdef UART_RX_CTRL_PARITY_EN
            vectors++; if (n_perr !== e_perr) begin miscompares++; $display("FAIL b2b_perr[%0d]: got %0d want %0d", i, n_perr, e_perr); end
`endif
            if (e_valid && ($urandom_range(0, 1) == 1)) do_ack("b2b");
        end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef UART_RX_CTRL_PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
